serial_byte_rx: RTL and testbench
=================================

Name: serial_byte_rx

Overview:
Synchronous serial receiver for the pad side of the chip.
- Host shifts words in on one io_in pin (SDI), framed by an enable pin (SEN), timed by the design clock.
- Block assembles DATA_W-bit words MSB-first and buffers them in a small first-word-fall-through FIFO.
- Downstream logic reads the FIFO with a pop strobe.
- Inbound counterpart to the io_out drive path of the top-level shell; sits between io_in pins and core circuit.

Parameters:
DATA_W, 8, word width in bits (>=2)
FIFO_DEPTH, 4, FIFO entries (power of 2, >=2)

Ports:
CLK  input  1  design clock; all logic on rising edge
RST  input  1  reset, synchronous, active-low
SDI  input  1  serial data, sampled on rising CLK edge
SEN  input  1  frame enable, active-high; each CLK with SEN=1 samples one bit
POP  input  1  pop FIFO head; ignored when VALID=0
CLR_ERR  input  1  clears sticky error flags
DOUT  output  DATA_W  FIFO head word; forced 0 when FIFO empty
VALID  output  1  FIFO not empty
FULL  output  1  FIFO holds FIFO_DEPTH words
OVF  output  1  sticky: a completed word was dropped because FIFO was full
FRAME_ERR  output  1  sticky: SEN dropped mid-word
PAR_ERR  output  1  sticky parity error (see Optional Feature)

Behaviour:
- Reset (RST=0 at CLK edge):
  - shift register, bit counter and FIFO pointers/count cleared; FSM to IDLE.
  - Outputs: DOUT=0, VALID=0, FULL=0, OVF=0, FRAME_ERR=0, PAR_ERR=0.
  - Reset mid-word discards the partial word with no error flag.
- FSM states:
  - IDLE: SEN=1 samples SDI as the MSB, count=1, go to SHIFT.
  - SHIFT:
    - SEN=1: shift SDI in at the LSB, count+1.
    - When count reaches DATA_W (last data bit sampled this cycle), the word is complete and count returns to 0.
    - SEN still 1 next cycle: next word starts back-to-back, no gap needed.
    - SEN=0 with count=0: go to IDLE, no error.
    - SEN=0 with count in 1..DATA_W-1: discard partial word, set FRAME_ERR, go to IDLE.
- Push latency: completed word is written to the FIFO on the edge after its last bit.
  - If the FIFO was empty, VALID=1 and DOUT=word are visible in that cycle, one cycle after the last-bit edge.
- FIFO:
  - First-word-fall-through; DOUT combinationally reflects the head entry.
  - POP with VALID=1 advances the head at the clock edge; POP with VALID=0 has no effect.
  - Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- Simultaneous push and pop:
  - Not full: both happen, count unchanged.
  - Full: the pop frees a slot, the push is accepted, OVF is not set.
- Push when full with no pop: word dropped, FIFO unchanged, OVF set.
- Sticky flags: CLR_ERR=1 clears OVF, FRAME_ERR and PAR_ERR. If a set event and CLR_ERR occur in the same cycle, set wins.
- SEN/SDI are expected to be synchronous to CLK; no internal synchronizer.

Optional Feature:
PARITY_EN
- Defined:
  - Each word carries one extra bit after the DATA_W data bits; total frame is DATA_W+1 bits.
  - Even parity over data plus parity bit.
  - Match: word pushed, with the same latency measured from the parity bit.
  - Mismatch: word discarded, PAR_ERR set, no push, OVF unaffected.
  - SEN dropping before the parity bit counts as FRAME_ERR.
- Undefined: no parity bit; frame is DATA_W bits; PAR_ERR tied 0.

Test Plan:
1. Reset, then SEN=1 for 8 cycles with SDI=1,0,1,0,0,1,0,1 -> one cycle after the 8th bit: VALID=1, DOUT=0xA5. POP=1 for one cycle -> VALID=0, DOUT=0.
2. Stream 5 words 0x01..0x05 back-to-back with SEN held high, no POP -> FULL=1 after 4th word, OVF=1 after 5th. Pop 4 times -> DOUT sequence 0x01,0x02,0x03,0x04, then VALID=0.
3. FIFO full, last bit of a 5th word lands in the cycle before POP=1 (push and pop on the same edge) -> OVF stays 0, FULL stays 1, head advances to 2nd word.
4. SEN=1 for 3 bits, then SEN=0 -> FRAME_ERR=1, VALID=0. Next full 8-bit frame 0x3C -> DOUT=0x3C. CLR_ERR=1 -> FRAME_ERR=0.
5. RST=0 asserted after 5 bits of a frame with 2 words queued -> next cycle all outputs 0. Following fresh frame 0x7E received correctly.
6. PARITY_EN: frame 0xA5 with parity bit 0 -> DOUT=0xA5, PAR_ERR=0. Frame 0xA5 with parity bit 1 -> no push, PAR_ERR=1.

Source files
------------

// File: rtl/serial_byte_rx_if.sv
// rtl/serial_byte_rx_if.sv - pin-side and FIFO-side signals of serial_byte_rx
interface serial_byte_rx_if #(
  parameter int DATA_W = 8
);
  logic              SDI;
  logic              SEN;
  logic              POP;
  logic              CLR_ERR;
  logic [DATA_W-1:0] DOUT;
  logic              VALID;
  logic              FULL;
  logic              OVF;
  logic              FRAME_ERR;
  logic              PAR_ERR;

  modport master (
    output SDI, SEN, POP, CLR_ERR,
    input  DOUT, VALID, FULL, OVF, FRAME_ERR, PAR_ERR
  );

  modport slave (
    input  SDI, SEN, POP, CLR_ERR,
    output DOUT, VALID, FULL, OVF, FRAME_ERR, PAR_ERR
  );
endinterface

// File: rtl/serial_byte_rx.sv
// rtl/serial_byte_rx.sv - MSB-first serial word receiver feeding a FWFT FIFO
// Optional even-parity bit per frame enabled by defining PARITY_EN.
module serial_byte_rx #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  serial_byte_rx_if.slave  bus
);

`ifdef PARITY_EN
  localparam int FRAME_BITS = DATA_W + 1;
`else
  localparam int FRAME_BITS = DATA_W;
`endif
  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [CW-1:0]     r_bit_cnt;
  logic              r_done;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_ovf;
  logic              r_frame_err;
`ifdef PARITY_EN
  logic              r_par_ok;
  logic              r_par_err;
`endif

  logic [DATA_W-1:0] w_shifted;
  logic              w_last;
  logic              w_full;
  logic              w_valid;
  logic              w_pop;
  logic              w_push_req;
  logic              w_push;
  logic              w_drop;
  logic              w_frame_abort;

  assign w_shifted     = {r_shift[DATA_W-2:0], bus.SDI};
  assign w_last        = (r_bit_cnt == LAST_BIT);
  assign w_full        = (r_count == DEPTH_C);
  assign w_valid       = (r_count != '0);
  assign w_pop         = bus.POP && w_valid;
`ifdef PARITY_EN
  assign w_push_req    = r_done && r_par_ok;
`else
  assign w_push_req    = r_done;
`endif
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign w_push        = w_push_req && (!w_full || w_pop);
  assign w_drop        = w_push_req && !w_push;
  assign w_frame_abort = (r_state == S_SHIFT) && !bus.SEN && (r_bit_cnt != '0);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_done      <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef PARITY_EN
      r_par_ok    <= 1'b0;
      r_par_err   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.SEN) begin
            r_shift   <= w_shifted;
            r_bit_cnt <= CW'(1);
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (bus.SEN) begin
`ifdef PARITY_EN
            // Parity bit is checked but not shifted, so r_shift holds the word.
            if (w_last) r_par_ok <= ~(^r_shift ^ bus.SDI);
            else        r_shift  <= w_shifted;
`else
            r_shift <= w_shifted;
`endif
            if (w_last) begin
              r_done    <= 1'b1;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_drop)           r_ovf <= 1'b1;
      else if (bus.CLR_ERR) r_ovf <= 1'b0;
      if (w_frame_abort)    r_frame_err <= 1'b1;
      else if (bus.CLR_ERR) r_frame_err <= 1'b0;
`ifdef PARITY_EN
      if (r_done && !r_par_ok) r_par_err <= 1'b1;
      else if (bus.CLR_ERR)    r_par_err <= 1'b0;
`endif
    end
  end

  // The completed word is still in r_shift on the push edge, even if the next frame starts.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= r_shift;
  end

  assign bus.DOUT      = w_valid ? r_mem[r_rd_ptr] : '0;
  assign bus.VALID     = w_valid;
  assign bus.FULL      = w_full;
  assign bus.OVF       = r_ovf;
  assign bus.FRAME_ERR = r_frame_err;
`ifdef PARITY_EN
  assign bus.PAR_ERR   = r_par_err;
`else
  assign bus.PAR_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_serial_byte_rx.sv
// tb/tb_serial_byte_rx.sv - directed, table-driven bench for serial_byte_rx
module tb_serial_byte_rx;
  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  serial_byte_rx_if #(.DATA_W(8)) bus ();

  serial_byte_rx #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    int         nbits;
    logic       exp_valid;
    logic [7:0] exp_dout;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Entered at a negedge; leaves at the negedge after the last sampled bit with SEN still high.
  task automatic drive_frame(input logic [7:0] d, input int nbits);
    for (int b = 0; b < nbits; b++) begin
      bus.SEN = 1'b1;
      bus.SDI = d[7-b];
      @(negedge CLK);
    end
`ifdef PARITY_EN
    if (nbits == 8) begin
      bus.SDI = ^d;
      @(negedge CLK);
    end
`endif
  endtask

  task automatic pop_once();
    bus.POP = 1'b1;
    @(negedge CLK);
    bus.POP = 1'b0;
  endtask

  task automatic clr_err();
    bus.CLR_ERR = 1'b1;
    @(negedge CLK);
    bus.CLR_ERR = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_word;
    checks = 0;
    errors = 0;
    vecs[0] = '{8'hA5, 8, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'h3C, 8, 1'b1, 8'h3C, 1'b0};
    vecs[2] = '{8'hFF, 8, 1'b1, 8'hFF, 1'b0};
    vecs[3] = '{8'h00, 8, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{8'h81, 3, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h7E, 7, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h5A, 1, 1'b0, 8'h00, 1'b1};

    RST = 1'b0;
    bus.SDI = 1'b0;
    bus.SEN = 1'b0;
    bus.POP = 1'b0;
    bus.CLR_ERR = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_valid", bus.VALID, 0);
    chk("rst_dout", bus.DOUT, 0);
    chk("rst_full", bus.FULL, 0);
    chk("rst_ovf", bus.OVF, 0);
    chk("rst_ferr", bus.FRAME_ERR, 0);
    chk("rst_perr", bus.PAR_ERR, 0);
    RST = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 7; i++) begin
      drive_frame(vecs[i].data, vecs[i].nbits);
      chk($sformatf("v%0d_latency_valid", i), bus.VALID, 0);
      bus.SEN = 1'b0;
      @(negedge CLK);
      chk($sformatf("v%0d_valid", i), bus.VALID, vecs[i].exp_valid);
      chk($sformatf("v%0d_dout", i), bus.DOUT, vecs[i].exp_dout);
      chk($sformatf("v%0d_ferr", i), bus.FRAME_ERR, vecs[i].exp_ferr);
      bus.POP = 1'b1;
      bus.CLR_ERR = 1'b1;
      @(negedge CLK);
      bus.POP = 1'b0;
      bus.CLR_ERR = 1'b0;
      chk($sformatf("v%0d_post_valid", i), bus.VALID, 0);
      chk($sformatf("v%0d_post_dout", i), bus.DOUT, 0);
      chk($sformatf("v%0d_post_ferr", i), bus.FRAME_ERR, 0);
    end

    // Back-to-back stream of five words with no pop: fifth is dropped.
    for (int w = 1; w <= 4; w++) drive_frame(8'(w), 8);
    chk("stream_full_before_w4_push", bus.FULL, 0);
    drive_frame(8'h05, 8);
    chk("stream_full_after_w4", bus.FULL, 1);
    chk("stream_ovf_before_w5_push", bus.OVF, 0);
    bus.SEN = 1'b0;
    @(negedge CLK);
    chk("stream_ovf_after_w5", bus.OVF, 1);
    chk("stream_full_hold", bus.FULL, 1);
    for (int w = 1; w <= 4; w++) begin
      chk($sformatf("stream_pop%0d_dout", w), bus.DOUT, w);
      pop_once();
    end
    chk("stream_empty_valid", bus.VALID, 0);
    chk("stream_empty_dout", bus.DOUT, 0);
    clr_err();
    chk("stream_ovf_cleared", bus.OVF, 0);

    // Full FIFO with push and pop on the same edge.
    for (int w = 0; w < 5; w++) drive_frame(8'h11 + 8'(w), 8);
    bus.SEN = 1'b0;
    bus.POP = 1'b1;
    @(negedge CLK);
    bus.POP = 1'b0;
    chk("pp_ovf", bus.OVF, 0);
    chk("pp_full", bus.FULL, 1);
    chk("pp_head", bus.DOUT, 8'h12);
    for (int w = 0; w < 4; w++) begin
      exp_word = 8'h12 + 8'(w);
      chk($sformatf("pp_pop%0d_dout", w), bus.DOUT, exp_word);
      pop_once();
    end
    chk("pp_empty_valid", bus.VALID, 0);

    // Reset mid-frame with two words queued.
    drive_frame(8'h21, 8);
    drive_frame(8'h22, 8);
    drive_frame(8'h99, 5);
    chk("mrst_pre_valid", bus.VALID, 1);
    chk("mrst_pre_dout", bus.DOUT, 8'h21);
    RST = 1'b0;
    bus.SEN = 1'b0;
    @(negedge CLK);
    chk("mrst_valid", bus.VALID, 0);
    chk("mrst_dout", bus.DOUT, 0);
    chk("mrst_full", bus.FULL, 0);
    chk("mrst_ovf", bus.OVF, 0);
    chk("mrst_ferr", bus.FRAME_ERR, 0);
    RST = 1'b1;
    @(negedge CLK);
    drive_frame(8'h7E, 8);
    bus.SEN = 1'b0;
    @(negedge CLK);
    chk("mrst_fresh_valid", bus.VALID, 1);
    chk("mrst_fresh_dout", bus.DOUT, 8'h7E);
    chk("mrst_fresh_ferr", bus.FRAME_ERR, 0);
    pop_once();
    chk("mrst_fresh_popped", bus.VALID, 0);

`ifdef PARITY_EN
    drive_frame(8'hA5, 8);
    bus.SEN = 1'b0;
    @(negedge CLK);
    chk("par_good_dout", bus.DOUT, 8'hA5);
    chk("par_good_perr", bus.PAR_ERR, 0);
    pop_once();
    for (int b = 0; b < 8; b++) begin
      bus.SEN = 1'b1;
      bus.SDI = vecs[0].data[7-b];
      @(negedge CLK);
    end
    bus.SDI = 1'b1;
    @(negedge CLK);
    bus.SEN = 1'b0;
    @(negedge CLK);
    chk("par_bad_valid", bus.VALID, 0);
    chk("par_bad_perr", bus.PAR_ERR, 1);
    chk("par_bad_ovf", bus.OVF, 0);
    clr_err();
    chk("par_cleared", bus.PAR_ERR, 0);
`else
    chk("par_tied_low", bus.PAR_ERR, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
